imm_decode_ctrl: RTL and testbench

//  Decode-stage sequencer for the RV32I immediate generator. Accepts fetched

---
 rtl/imm_decode_ctrl.sv | 132 +++++++++++++
 tb/tb_imm_decode_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// rtl/imm_decode_ctrl.sv - RV32I decode-stage sequencer feeding the immediate generator
//
// Classifies fetched instructions into immediate format codes and registers
// inst/pc/type toward execute. Illegal opcodes park the block in TRAP until
// trap_ack. flush kills the held and incoming instruction.
//
// Ports:
//   clk, nRst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    fetch-side handshake carrying inst_i, pc_i
//   flush                synchronous kill, overrides every other control
//   out_valid/out_ready  execute-side handshake carrying inst_o, pc_o, type_o
//   type_o               0 none(R), 1 I, 2 S, 3 SB, 4 UJ, 5 U
//   illegal_o, trap_ack  trap indication and release
//   dec_cnt_o            saturating count of execute-side handshakes
module imm_decode_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        type_o,
  output logic              illegal_o,
  input  logic              trap_ack,
  output logic [CNT_W-1:0]  dec_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         inst_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [2:0]          type_q;
  logic                valid_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                dec_legal;
  logic [2:0]          dec_type;
  logic                accept;
  logic                out_fire;

  // Opcode classification; anything unlisted (including compressed encodings
  // with inst_i[1:0] != 2'b11) is illegal.
  always_comb begin
    dec_legal = 1'b1;
    dec_type  = 3'd0;
    case (inst_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:             dec_type = 3'd1;
      7'b0100011:                         dec_type = 3'd2;
      7'b1100011:                         dec_type = 3'd3;
      7'b1101111:                         dec_type = 3'd4;
      7'b0110111, 7'b0010111:             dec_type = 3'd5;
      7'b0110011:                         dec_type = 3'd0;
      default:                            dec_legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == ST_EMPTY) | ((state_q == ST_VALID) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = valid_q & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = dec_legal ? ST_VALID : ST_TRAP;
        ST_VALID: begin
          // With out_ready high the slot frees, so a new accept refills it
          // in the same cycle and no bubble appears.
          if (accept)         state_d = dec_legal ? ST_VALID : ST_TRAP;
          else if (out_ready) state_d = ST_EMPTY;
        end
        ST_TRAP:  if (trap_ack) state_d = ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      type_q    <= 3'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= (state_d == ST_VALID);
      illegal_q <= (state_d == ST_TRAP);
      cnt_q     <= cnt_d;
      if (accept) begin
        // An illegal instruction is kept for the trap handler with type 0.
        inst_q <= inst_i;
        pc_q   <= pc_i;
        type_q <= dec_legal ? dec_type : 3'd0;
      end
    end
  end

  assign out_valid = valid_q;
  assign illegal_o = illegal_q;
  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign type_o    = type_q;
  assign dec_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb/tb_imm_decode_ctrl.sv - self-checking bench for imm_decode_ctrl
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        nRst;
  logic        in_valid, flush, out_ready, trap_ack;
  logic [31:0] inst_i, pc_i;

  logic        in_ready, out_valid, illegal_o;
  logic [31:0] inst_o, pc_o;
  logic [2:0]  type_o;
  logic [15:0] dec_cnt_o;

  logic        in_ready2, out_valid2, illegal2;
  logic [31:0] inst2, pc2;
  logic [2:0]  type2;
  logic [1:0]  dec_cnt2;

  int checks = 0;
  int errors = 0;

  // reference model state: one holding slot, a trap flag, handshake tally
  bit          m_full, m_trap;
  logic [31:0] m_inst, m_pc;
  logic [2:0]  m_type;
  int          m_hs;

  logic [6:0] ops_tab [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                               7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
  int         typ_tab [11] = '{1, 1, 1, 1, 1, 2, 3, 4, 5, 5, 0};

  always #5 clk = ~clk;

  imm_decode_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .pc_i(pc_i), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .inst_o(inst_o), .pc_o(pc_o), .type_o(type_o),
    .illegal_o(illegal_o), .trap_ack(trap_ack), .dec_cnt_o(dec_cnt_o)
  );

  imm_decode_ctrl #(.ADDR_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready2),
    .inst_i(inst_i), .pc_i(pc_i), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .inst_o(inst2), .pc_o(pc2), .type_o(type2),
    .illegal_o(illegal2), .trap_ack(trap_ack), .dec_cnt_o(dec_cnt2)
  );

  function automatic int ref_type(input logic [31:0] ins);
    for (int k = 0; k < 11; k++) if (ins[6:0] == ops_tab[k]) return typ_tab[k];
    return -1;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit model_ready(input bit ordy);
    return !m_trap && (!m_full || ordy);
  endfunction

  task automatic model_reset();
    m_full = 0; m_trap = 0; m_inst = '0; m_pc = '0; m_type = '0; m_hs = 0;
  endtask

  task automatic model_step();
    bit rdy, take, hs;
    int t;
    rdy  = model_ready(out_ready);
    hs   = m_full && out_ready && !flush;
    take = in_valid && rdy && !flush;
    t    = ref_type(inst_i);
    if (hs) m_hs++;
    if (flush) begin
      m_full = 0; m_trap = 0;
    end else if (m_trap) begin
      if (trap_ack) m_trap = 0;
    end else if (take) begin
      m_inst = inst_i; m_pc = pc_i;
      if (t < 0) begin m_full = 0; m_trap = 1; m_type = 3'd0; end
      else       begin m_full = 1; m_type = 3'(t); end
    end else if (hs) begin
      m_full = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy, input logic ack);
    in_valid = v; inst_i = ins; pc_i = pc; flush = fl; out_ready = ordy; trap_ack = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b exp 0", illegal_o); end
    checks++; if (inst_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h/%h exp 0/0", inst_o, pc_o); end
    checks++; if (type_o !== 3'd0 || dec_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_type_cnt got %0d/%0d exp 0/0", type_o, dec_cnt_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    drive(1, 32'h00A00093, 32'h0000_0100, 0, 1, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || type_o !== 3'd1) begin errors++; $display("FAIL addi_valid_type got %0b/%0d exp 1/1", out_valid, type_o); end
    checks++; if (inst_o !== 32'h00A00093 || pc_o !== 32'h100) begin errors++; $display("FAIL addi_inst_pc got %h/%h exp 00a00093/00000100", inst_o, pc_o); end
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b0 || dec_cnt_o !== 16'(m_hs)) begin errors++; $display("FAIL addi_drain got %0b/%0d exp 0/%0d", out_valid, dec_cnt_o, m_hs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [5] = '{32'h00112623, 32'h00208463, 32'h008000EF, 32'h123450B7, 32'h002081B3};
    logic [2:0]  exp [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    int start;
    start = m_hs;
    for (int i = 0; i < 5; i++) begin
      drive(1, seq[i], 32'h200 + 32'(4 * i), 0, 1, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %0b exp 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || type_o !== exp[i] || inst_o !== seq[i]) begin
        errors++; $display("FAIL b2b_out[%0d] got v=%0b t=%0d i=%h exp v=1 t=%0d i=%h", i, out_valid, type_o, inst_o, exp[i], seq[i]); end
    end
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    tick();
    checks++; if (dec_cnt_o !== 16'(start + 5)) begin errors++; $display("FAIL b2b_count got %0d exp %0d", dec_cnt_o, start + 5); end
  endtask

  task automatic test_stall();
    int start;
    drive(1, 32'h00452183, 32'h300, 0, 1, 0);
    tick();
    start = m_hs;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00000013, 32'h304, 0, 0, 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b exp 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || inst_o !== 32'h00452183 || type_o !== 3'd1 || dec_cnt_o !== 16'(start)) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%0b i=%h t=%0d c=%0d exp v=1 i=00452183 t=1 c=%0d", i, out_valid, inst_o, type_o, dec_cnt_o, start); end
    end
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b0 || dec_cnt_o !== 16'(start + 1)) begin errors++; $display("FAIL stall_release got v=%0b c=%0d exp v=0 c=%0d", out_valid, dec_cnt_o, start + 1); end
  endtask

  task automatic test_trap();
    drive(1, 32'hFFFFFFFF, 32'h400, 0, 1, 0);
    tick();
    drive(1, 32'h00A00093, 32'h404, 0, 1, 0);
    checks++; if (illegal_o !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL trap_enter got ill=%0b v=%0b rdy=%0b exp 1/0/0", illegal_o, out_valid, in_ready); end
    tick();
    checks++; if (inst_o !== 32'hFFFFFFFF || pc_o !== 32'h400 || type_o !== 3'd0 || illegal_o !== 1'b1) begin
      errors++; $display("FAIL trap_hold got i=%h pc=%h t=%0d ill=%0b exp ffffffff/400/0/1", inst_o, pc_o, type_o, illegal_o); end
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    checks++; if (illegal_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL trap_ack got ill=%0b rdy=%0b exp 0/1", illegal_o, in_ready); end
  endtask

  task automatic test_flush();
    int start;
    drive(1, 32'h00812023, 32'h500, 0, 1, 0);
    tick();
    start = m_hs;
    drive(1, 32'h00000037, 32'h504, 1, 1, 0);
    tick();
    checks++; if (out_valid !== 1'b0 || inst_o !== 32'h00812023 || dec_cnt_o !== 16'(start)) begin
      errors++; $display("FAIL flush_valid got v=%0b i=%h c=%0d exp 0/00812023/%0d", out_valid, inst_o, dec_cnt_o, start); end
    drive(1, 32'h00000000, 32'h508, 0, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    checks++; if (illegal_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_trap got ill=%0b rdy=%0b exp 0/1", illegal_o, in_ready); end
  endtask

  task automatic test_saturate_reset();
    nRst = 1'b0; #1; nRst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h00100093, 32'h600 + 32'(4 * i), 0, 1, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    tick();
    checks++; if (dec_cnt2 !== 2'd3 || dec_cnt_o !== 16'd5) begin errors++; $display("FAIL sat_count got %0d/%0d exp 3/5", dec_cnt2, dec_cnt_o); end
    drive(1, 32'h00100093, 32'h700, 0, 0, 0);
    tick();
    #2 nRst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0 || type_o !== 3'd0 || dec_cnt_o !== 16'd0 || dec_cnt2 !== 2'd0 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%0b i=%h pc=%h t=%0d c=%0d/%0d exp all 0", out_valid, inst_o, pc_o, type_o, dec_cnt_o, dec_cnt2); end
    @(negedge clk);
    nRst = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) == 0) ins = $urandom;
      else ins = {25'($urandom), ops_tab[$urandom_range(10)]};
      drive(($urandom_range(9) < 7), ins, $urandom, ($urandom_range(9) == 0),
            ($urandom_range(9) < 6), ($urandom_range(9) < 3));
      checks++; if (in_ready !== model_ready(out_ready) || in_ready2 !== in_ready) begin
        errors++; $display("FAIL rnd_in_ready[%0d] got %0b/%0b exp %0b", n, in_ready, in_ready2, model_ready(out_ready)); end
      tick();
      checks++; if (out_valid !== m_full || illegal_o !== m_trap) begin
        errors++; $display("FAIL rnd_state[%0d] got v=%0b ill=%0b exp v=%0b ill=%0b", n, out_valid, illegal_o, m_full, m_trap); end
      checks++; if (inst_o !== m_inst || pc_o !== m_pc || type_o !== m_type) begin
        errors++; $display("FAIL rnd_data[%0d] got i=%h pc=%h t=%0d exp i=%h pc=%h t=%0d", n, inst_o, pc_o, type_o, m_inst, m_pc, m_type); end
      checks++; if (dec_cnt_o !== 16'(sat(m_hs, 65535)) || dec_cnt2 !== 2'(sat(m_hs, 3))) begin
        errors++; $display("FAIL rnd_count[%0d] got %0d/%0d exp %0d/%0d", n, dec_cnt_o, dec_cnt2, sat(m_hs, 65535), sat(m_hs, 3)); end
      checks++; if (out_valid2 !== m_full || illegal2 !== m_trap || inst2 !== m_inst || pc2 !== m_pc || type2 !== m_type) begin
        errors++; $display("FAIL rnd_narrow[%0d] got v=%0b ill=%0b i=%h t=%0d exp v=%0b ill=%0b i=%h t=%0d", n, out_valid2, illegal2, inst2, type2, m_full, m_trap, m_inst, m_type); end
    end
  endtask

  initial begin
    nRst = 1'b0;
    in_valid = 0; inst_i = '0; pc_i = '0; flush = 0; out_ready = 0; trap_ack = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_trap();
    test_flush();
    test_saturate_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
